// File: rtl/vga_frame_buffer_pkg.sv
// vga_pkg: shared definitions for the VGA frame buffer and its neighbours.
//   VGA_DEPTH   - entries per buffer
//   VGA_DATA_W  - entry width
//   fb_state_t  - frame buffer sequencer states
//   vga_byte_t  - one stored byte
package vga_pkg;

  localparam int VGA_DEPTH  = 65;
  localparam int VGA_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    WAIT_VS = 2'd2
  } fb_state_t;

  typedef logic [7:0] vga_byte_t;

endpackage

// File: rtl/vga_frame_buffer_edge_fall_det.sv
// edge_fall_det: registers a level signal and flags its falling edge.
//   clk, rst_n - clock, synchronous active-low reset
//   sig        - level input (e.g. active-low vsync)
//   fall       - high while sig_q==1 and sig==0 (combinational from the
//                registered copy and the live input)
// The register resets to 1 so a signal that is low out of reset is not
// mistaken for a fresh falling edge.
module edge_fall_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= 1'b1;
    else        sig_q <= sig;
  end

  assign fall = sig_q & ~sig;

endmodule

// File: rtl/vga_frame_buffer.sv
// vga_frame_buffer: double-buffered byte store feeding the VGA output stage.
//   clk, rst_n          - clock, synchronous active-low reset
//   wr_valid/wr_ready   - producer write handshake
//   wr_sel              - 0: array entry, 1: display byte
//   wr_addr, wr_data    - write index / data
//   clear_req           - zero the back array
//   commit              - publish back buffer at the next vsync falling edge
//   vsync               - active-low vertical sync
//   ram, display        - front buffer (registered)
//   busy                - sequencer not idle
//   swap_done           - one-cycle pulse after a swap
//   wr_err              - one-cycle pulse after an out-of-range array write
//
// state   | meaning
// IDLE    | accepts writes, clear and commit
// CLEAR   | sweeping back[0..DEPTH-1] to zero, one entry per cycle
// WAIT_VS | commit pending, waiting for vsync falling edge
module vga_frame_buffer
  import vga_pkg::*;
#(
  parameter int DEPTH  = VGA_DEPTH,
  parameter int DATA_W = VGA_DATA_W,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_req,
  input  logic              commit,
  input  logic              vsync,
  output logic [DATA_W-1:0] ram [DEPTH-1:0],
  output logic [DATA_W-1:0] display,
  output logic              busy,
  output logic              swap_done,
  output logic              wr_err
);

  // Extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] back [DEPTH-1:0];
  logic [DATA_W-1:0] display_back;
  logic              vs_fall;
  logic              wr_fire;
  logic              addr_ok;

  edge_fall_det u_vs_fall (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (vsync),
    .fall  (vs_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        wr_ready = !clear_req && !commit;
        if (clear_req)   state_nxt = CLEAR;
        else if (commit) state_nxt = WAIT_VS;
      end
      CLEAR:   if (cnt == LAST) state_nxt = IDLE;
      WAIT_VS: if (vs_fall)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fire = wr_valid && wr_ready;
  assign addr_ok = {1'b0, wr_addr} < DEPTH_L;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      display_back <= '0;
      display      <= '0;
      swap_done    <= 1'b0;
      wr_err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        back[i] <= '0;
        ram[i]  <= '0;
      end
    end else begin
      swap_done <= 1'b0;
      // wr_addr is meaningless for display writes, so only array writes can err.
      wr_err    <= wr_fire && !wr_sel && !addr_ok;
      if (wr_fire) begin
        if (wr_sel)       display_back  <= wr_data;
        else if (addr_ok) back[wr_addr] <= wr_data;
      end
      if (state == CLEAR) begin
        back[cnt] <= '0;
        cnt       <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
      if (state == WAIT_VS && vs_fall) begin
        ram       <= back;
        display   <= display_back;
        swap_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_buffer.sv
module tb_vga_frame_buffer;

  localparam int DEPTH = 65;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_sel;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       clear_req;
  logic       commit;
  logic       vsync;
  logic [7:0] ram [DEPTH-1:0];
  logic [7:0] display;
  logic       busy;
  logic       swap_done;
  logic       wr_err;

  int tests  = 0;
  int errors = 0;

  // Hand-maintained expectation of the front buffer after each swap.
  logic [7:0] exp_ram [DEPTH-1:0];
  logic [7:0] exp_disp;

  always #5 clk = ~clk;

  vga_frame_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clear_req (clear_req),
    .commit    (commit),
    .vsync     (vsync),
    .ram       (ram),
    .display   (display),
    .busy      (busy),
    .swap_done (swap_done),
    .wr_err    (wr_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic sel, input logic [6:0] addr, input logic [7:0] data);
    wr_valid = 1'b1;
    wr_sel   = sel;
    wr_addr  = addr;
    wr_data  = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 8'h00) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL reset_ram: %0d nonzero entries, want 0", bad); end
    tests++; if (display !== 8'h00) begin errors++; $display("FAIL reset_display: got %h want 00", display); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (swap_done !== 1'b0) begin errors++; $display("FAIL reset_swap_done: got %b want 0", swap_done); end
    tests++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
    tests++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
  endtask

  task automatic test_basic_swap();
    do_write(1'b0, 7'd5, 8'hA3);
    commit = 1'b1;
    #1;
    tests++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL commit_blocks_ready: got %b want 0", wr_ready); end
    tick();
    commit = 1'b0;
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: got %b want 1", busy); end
    tick(); tick(); tick();
    tests++; if (ram[5] !== 8'h00) begin errors++; $display("FAIL preswap_ram5: got %h want 00", ram[5]); end
    tests++; if (swap_done !== 1'b0) begin errors++; $display("FAIL preswap_done: got %b want 0", swap_done); end
    vsync = 1'b0;
    tick();
    tests++; if (ram[5] !== 8'hA3) begin errors++; $display("FAIL swap_ram5: got %h want a3", ram[5]); end
    tests++; if (swap_done !== 1'b1) begin errors++; $display("FAIL swap_done_pulse: got %b want 1", swap_done); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL swap_busy: got %b want 0", busy); end
    tick();
    tests++; if (swap_done !== 1'b0) begin errors++; $display("FAIL swap_done_width: got %b want 0", swap_done); end
    vsync = 1'b1;
    tick();
    exp_ram[5] = 8'hA3;
  endtask

  task automatic test_display();
    int bad;
    do_write(1'b1, 7'd0, 8'h3C);
    do_commit();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    exp_disp = 8'h3C;
    tests++; if (display !== 8'h3C) begin errors++; $display("FAIL display_swap: got %h want 3c", display); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_ram[i]) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL display_other_entries: %0d entries differ", bad); end
  endtask

  task automatic test_wr_err();
    int bad;
    do_write(1'b0, 7'd70, 8'hFF);
    tests++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr_err_pulse: got %b want 1", wr_err); end
    tick();
    tests++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_width: got %b want 0", wr_err); end
    do_write(1'b0, 7'd64, 8'h5A);
    tests++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr_err_last_entry: got %b want 0", wr_err); end
    exp_ram[64] = 8'h5A;
    do_commit();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== exp_ram[i]) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL wr_err_no_store: %0d entries differ", bad); end
    tests++; if (display !== exp_disp) begin errors++; $display("FAIL wr_err_display: got %h want %h", display, exp_disp); end
  endtask

  task automatic test_clear();
    int bad;
    int cyc;
    int ready_hi;
    for (int i = 0; i < DEPTH; i++) do_write(1'b0, 7'(i), 8'h11);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cyc = 0;
    ready_hi = 0;
    wr_valid = 1'b1;
    wr_sel   = 1'b0;
    wr_addr  = 7'd3;
    wr_data  = 8'hEE;
    while (busy === 1'b1 && cyc < 200) begin
      if (wr_ready !== 1'b0) ready_hi++;
      cyc++;
      tick();
    end
    wr_valid = 1'b0;
    tests++; if (cyc != 65) begin errors++; $display("FAIL clear_busy_len: got %0d cycles want 65", cyc); end
    tests++; if (ready_hi != 0) begin errors++; $display("FAIL clear_wr_ready: high %0d cycles want 0", ready_hi); end
    do_commit();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_ram[i] = 8'h00;
      if (ram[i] !== 8'h00) bad++;
    end
    tests++; if (bad != 0) begin errors++; $display("FAIL clear_ram_zero: %0d nonzero entries", bad); end
    tests++; if (display !== 8'h3C) begin errors++; $display("FAIL clear_keeps_display: got %h want 3c", display); end
  endtask

  task automatic test_same_cycle();
    int ready_hi;
    do_write(1'b0, 7'd0, 8'h77);
    commit = 1'b1;
    vsync  = 1'b0;
    tick();
    commit = 1'b0;
    ready_hi = 0;
    tests++; if (swap_done !== 1'b0) begin errors++; $display("FAIL same_cycle_no_swap: got %b want 0", swap_done); end
    for (int i = 0; i < 4; i++) begin
      if (wr_ready !== 1'b0) ready_hi++;
      tick();
    end
    tests++; if (ram[0] !== 8'h00) begin errors++; $display("FAIL held_low_no_swap: got %h want 00", ram[0]); end
    tests++; if (busy !== 1'b1) begin errors++; $display("FAIL held_low_busy: got %b want 1", busy); end
    vsync = 1'b1;
    if (wr_ready !== 1'b0) ready_hi++;
    tick();
    vsync = 1'b0;
    if (wr_ready !== 1'b0) ready_hi++;
    tick();
    tests++; if (ready_hi != 0) begin errors++; $display("FAIL wait_vs_wr_ready: high %0d cycles want 0", ready_hi); end
    tests++; if (ram[0] !== 8'h77) begin errors++; $display("FAIL next_edge_swap: got %h want 77", ram[0]); end
    tests++; if (swap_done !== 1'b1) begin errors++; $display("FAIL next_edge_done: got %b want 1", swap_done); end
    vsync = 1'b1;
    tick();
  endtask

  task automatic test_reset_wait();
    int bad;
    int dones;
    do_write(1'b0, 7'd0, 8'h55);
    do_commit();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== 8'h00) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL rst_wait_ram: %0d nonzero entries", bad); end
    tests++; if (display !== 8'h00) begin errors++; $display("FAIL rst_wait_display: got %h want 00", display); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_busy: got %b want 0", busy); end
    dones = 0;
    vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (swap_done !== 1'b0) dones++;
    end
    vsync = 1'b1;
    tick();
    tests++; if (dones != 0) begin errors++; $display("FAIL rst_wait_no_done: %0d pulses want 0", dones); end
    // Back buffer must have been zeroed too: a fresh swap publishes zeros.
    do_commit();
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tests++; if (ram[0] !== 8'h00) begin errors++; $display("FAIL rst_wait_back_zero: got %h want 00", ram[0]); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_sel    = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
    commit    = 1'b0;
    vsync     = 1'b1;
    exp_disp  = 8'h00;
    for (int i = 0; i < DEPTH; i++) exp_ram[i] = 8'h00;
    test_reset();
    test_basic_swap();
    test_display();
    test_wr_err();
    test_clear();
    test_same_cycle();
    test_reset_wait();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
